// File: rtl/hdlc_pkg.sv
// Shared constants for the HDLC receive bridge: EMIF register map, RX FSM
// encoding and status-word bit positions.
package hdlc_pkg;

    localparam logic [23:0] ADDR_RAM_BASE = 24'h000100;
    localparam logic [23:0] ADDR_RX_LEN   = 24'h000200;
    localparam logic [23:0] ADDR_RX_STAT  = 24'h000201;
    localparam logic [23:0] ADDR_RX_ACK   = 24'h000202;
    localparam logic [9:0]  INT_WIDTH     = 10'd84;

    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_OVF_BIT  = 1;
    localparam int STAT_DROP_LSB = 2;
    localparam int STAT_ERR_LSB  = 8;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DROP = 2'd2,
        RX_DONE = 2'd3
    } rx_state_e;

    // The 256-byte buffer occupies one aligned 256-word page of the EMIF space.
    function automatic logic is_ram_addr(input logic [23:0] addr, input logic [23:0] base);
        return addr[23:8] == base[23:8];
    endfunction

endpackage

// File: rtl/hdlc_rx_byte_sync.sv
// Toggle-handshake crossing of HDLC byte/eof events from the bit clock into clk_100m.
// The source bus is held stable between events, so only the toggle is synchronised.
module hdlc_rx_byte_sync (
    input  logic       clk,
    input  logic       clk_100m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    input  logic       rx_eof,
    input  logic       rx_err,
    output logic       evt,
    output logic [7:0] evt_data,
    output logic       evt_eof,
    output logic       evt_err
);

    logic [7:0] src_data_q, src_data_d;
    logic       src_eof_q, src_eof_d;
    logic       src_err_q, src_err_d;
    logic       tg_q, tg_d;

    logic [2:0] sync_q, sync_d;
    logic       evt_q, evt_d;
    logic [7:0] data_q, data_d;
    logic       eof_q, eof_d;
    logic       err_q, err_d;

    always_comb begin
        src_data_d = src_data_q;
        src_eof_d  = src_eof_q;
        src_err_d  = src_err_q;
        tg_d       = tg_q;
        if (rx_vld || rx_eof) begin
            src_data_d = rx_data;
            src_eof_d  = rx_eof;
            src_err_d  = rx_err & rx_eof;
            tg_d       = ~tg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_data_q <= 8'h00;
            src_eof_q  <= 1'b0;
            src_err_q  <= 1'b0;
            tg_q       <= 1'b0;
        end else begin
            src_data_q <= src_data_d;
            src_eof_q  <= src_eof_d;
            src_err_q  <= src_err_d;
            tg_q       <= tg_d;
        end
    end

    // sync_q[1] is the first settled copy; the payload has been stable for several cycles by then.
    always_comb begin
        sync_d = {sync_q[1:0], tg_q};
        evt_d  = sync_q[1] ^ sync_q[2];
        data_d = data_q;
        eof_d  = eof_q;
        err_d  = err_q;
        if (evt_d) begin
            data_d = src_data_q;
            eof_d  = src_eof_q;
            err_d  = src_err_q;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
            evt_q  <= 1'b0;
            data_q <= 8'h00;
            eof_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            evt_q  <= evt_d;
            data_q <= data_d;
            eof_q  <= eof_d;
            err_q  <= err_d;
        end
    end

    assign evt      = evt_q;
    assign evt_data = data_q;
    assign evt_eof  = eof_q;
    assign evt_err  = err_q;

endmodule

// File: rtl/dsp_hdlc_rx_ctrl.sv
// Receive-side DSP/HDLC bridge: buffers one HDLC frame in a 256x8 RAM, interrupts the DSP
// with the length, serves EMIF reads and drops/counts frames arriving while one is held.
module dsp_hdlc_rx_ctrl
    import hdlc_pkg::*;
#(
    parameter logic [23:0] P_RAM_BASE  = ADDR_RAM_BASE,
    parameter logic [23:0] P_RX_LEN    = ADDR_RX_LEN,
    parameter logic [23:0] P_RX_STAT   = ADDR_RX_STAT,
    parameter logic [23:0] P_RX_ACK    = ADDR_RX_ACK,
    parameter logic [9:0]  P_INT_WIDTH = INT_WIDTH
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        clk,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    input  logic        rx_eof,
    input  logic        rx_err,
    input  logic        emif_dpram_wen,
    input  logic        emif_dpram_ren,
    input  logic [23:0] emif_dpram_addr,
    input  logic [15:0] emif_data,
    output logic [15:0] emif_rdata,
    output logic        rx_int
);

    logic       evt;
    logic [7:0] evt_data;
    logic       evt_eof;
    logic       evt_err;

    hdlc_rx_byte_sync u_sync (
        .clk      (clk),
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .rx_eof   (rx_eof),
        .rx_err   (rx_err),
        .evt      (evt),
        .evt_data (evt_data),
        .evt_eof  (evt_eof),
        .evt_err  (evt_err)
    );

    rx_state_e   state_q, state_d;
    logic [8:0]  wptr_q, wptr_d;
    logic [8:0]  len_q, len_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [5:0]  drop_cnt_q, drop_cnt_d;
    logic [9:0]  int_cnt_q, int_cnt_d;
    logic        rx_int_q, rx_int_d;
    logic        rd_is_ram_q, rd_is_ram_d;
    logic [15:0] reg_rdata_q, reg_rdata_d;

    logic        byte_evt;
    logic        end_evt;
    logic        ack;
    logic        busy_v;
    logic        int_start;
    logic        ram_we;
    logic [7:0]  ram_waddr;
    logic [15:0] stat_word;

    logic [7:0]  mem [256];
    logic [7:0]  ram_rd_q;

    assign byte_evt = evt & ~evt_eof;
    assign end_evt  = evt & evt_eof;
    assign ack      = emif_dpram_wen && (emif_dpram_addr == P_RX_ACK);

    always_comb begin
        stat_word = 16'h0000;
        stat_word[STAT_ERR_LSB +: 8]  = err_cnt_q;
        stat_word[STAT_DROP_LSB +: 6] = drop_cnt_q;
        stat_word[STAT_OVF_BIT]       = ovf_q;
        stat_word[STAT_DONE_BIT]      = done_q;
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        len_d      = len_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        busy_v     = busy_q;
        int_start  = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wptr_q[7:0];

        case (state_q)
            RX_IDLE: begin
                if (byte_evt) begin
                    ram_we    = 1'b1;
                    ram_waddr = 8'h00;
                    wptr_d    = 9'd1;
                    ovf_d     = 1'b0;
                    state_d   = RX_RECV;
                end
            end
            RX_RECV: begin
                if (byte_evt) begin
                    if (wptr_q[8]) begin
                        ovf_d   = 1'b1;
                        state_d = RX_DROP;
                    end else begin
                        ram_we = 1'b1;
                        wptr_d = wptr_q + 9'd1;
                    end
                end else if (end_evt) begin
                    if (evt_err) begin
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        state_d = RX_IDLE;
                    end else begin
                        len_d     = wptr_q;
                        done_d    = 1'b1;
                        int_start = (int_cnt_q == 10'd0);
                        state_d   = RX_DONE;
                    end
                end
            end
            RX_DROP: begin
                if (end_evt) state_d = RX_IDLE;
            end
            RX_DONE: begin
                // Event is resolved against the held frame before an ACK in the same cycle.
                if (byte_evt) begin
                    busy_v = 1'b1;
                end else if (end_evt) begin
                    busy_v = 1'b0;
                    if (drop_cnt_q != 6'h3F) drop_cnt_d = drop_cnt_q + 6'd1;
                end
                busy_d = busy_v;
                if (ack) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = busy_v ? RX_DROP : RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        int_cnt_d = int_cnt_q;
        rx_int_d  = 1'b0;
        if (int_start) begin
            int_cnt_d = P_INT_WIDTH;
            rx_int_d  = 1'b1;
        end else if (int_cnt_q != 10'd0) begin
            int_cnt_d = int_cnt_q - 10'd1;
            rx_int_d  = (int_cnt_q != 10'd1);
        end
    end

    always_comb begin
        rd_is_ram_d = rd_is_ram_q;
        reg_rdata_d = reg_rdata_q;
        if (emif_dpram_ren) begin
            rd_is_ram_d = is_ram_addr(emif_dpram_addr, P_RAM_BASE);
            if (emif_dpram_addr == P_RX_LEN)       reg_rdata_d = {7'b0, len_q};
            else if (emif_dpram_addr == P_RX_STAT) reg_rdata_d = stat_word;
            else                                   reg_rdata_d = 16'h0000;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            wptr_q      <= 9'd0;
            len_q       <= 9'd0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
            drop_cnt_q  <= 6'd0;
            int_cnt_q   <= 10'd0;
            rx_int_q    <= 1'b0;
            rd_is_ram_q <= 1'b0;
            reg_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            len_q       <= len_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            int_cnt_q   <= int_cnt_d;
            rx_int_q    <= rx_int_d;
            rd_is_ram_q <= rd_is_ram_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    // Buffer RAM: plain write port plus an enabled read register so the data holds between reads.
    always_ff @(posedge clk_100m) begin
        if (ram_we) mem[ram_waddr] <= evt_data;
        if (emif_dpram_ren) ram_rd_q <= mem[emif_dpram_addr[7:0]];
    end

    assign emif_rdata = rd_is_ram_q ? {8'h00, ram_rd_q} : reg_rdata_q;
    assign rx_int     = rx_int_q;

endmodule

// File: tb/tb_dsp_hdlc_rx_ctrl.sv
// Directed bench for dsp_hdlc_rx_ctrl: HDLC byte driver on clk, EMIF driver on clk_100m,
// rx_int pulse monitor and hand-computed expected register/RAM values.
module tb_dsp_hdlc_rx_ctrl;
    import hdlc_pkg::*;

    logic        clk_100m;
    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_eof;
    logic        rx_err;
    logic        emif_dpram_wen;
    logic        emif_dpram_ren;
    logic [23:0] emif_dpram_addr;
    logic [15:0] emif_data;
    logic [15:0] emif_rdata;
    logic        rx_int;

    int checks = 0;
    int errors = 0;
    int int_pulses = 0;
    int int_width = 0;
    int int_run = 0;
    int p0;

    dsp_hdlc_rx_ctrl dut (
        .clk_100m        (clk_100m),
        .rst_n           (rst_n),
        .clk             (clk),
        .rx_data         (rx_data),
        .rx_vld          (rx_vld),
        .rx_eof          (rx_eof),
        .rx_err          (rx_err),
        .emif_dpram_wen  (emif_dpram_wen),
        .emif_dpram_ren  (emif_dpram_ren),
        .emif_dpram_addr (emif_dpram_addr),
        .emif_data       (emif_data),
        .emif_rdata      (emif_rdata),
        .rx_int          (rx_int)
    );

    // clock/reset
    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;
    initial clk = 1'b0;
    always #25 clk = ~clk;

    // rx_int pulse monitor: counts pulses and records the width of the last one
    always @(negedge clk_100m) begin
        if (rx_int) begin
            int_run++;
        end else if (int_run != 0) begin
            int_width = int_run;
            int_pulses++;
            int_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_vld  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_vld  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_eof(input logic err);
        @(negedge clk);
        rx_eof = 1'b1;
        rx_err = err;
        @(negedge clk);
        rx_eof = 1'b0;
        rx_err = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic emif_read(input logic [23:0] addr, output logic [15:0] d);
        @(negedge clk_100m);
        emif_dpram_ren  = 1'b1;
        emif_dpram_addr = addr;
        @(negedge clk_100m);
        emif_dpram_ren  = 1'b0;
        d = emif_rdata;
    endtask

    task automatic check_rd(input string tag, input logic [23:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        emif_read(addr, d);
        check_eq(tag, {16'h0, d}, {16'h0, exp});
    endtask

    task automatic emif_ack();
        @(negedge clk_100m);
        emif_dpram_wen  = 1'b1;
        emif_dpram_addr = ADDR_RX_ACK;
        emif_data       = 16'h1234;
        @(negedge clk_100m);
        emif_dpram_wen  = 1'b0;
        wait_cyc(2);
    endtask

    task automatic do_reset();
        @(negedge clk_100m);
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_data = 8'h00; rx_vld = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
        emif_dpram_wen = 1'b0; emif_dpram_ren = 1'b0;
        emif_dpram_addr = 24'h0; emif_data = 16'h0;

        // reset state
        wait_cyc(4);
        check_eq("rst_rdata", {16'h0, emif_rdata}, 32'h0);
        check_eq("rst_int", {31'h0, rx_int}, 32'h0);
        release_reset();
        check_eq("rst_state", 32'(dut.state_q), 32'(RX_IDLE));
        check_rd("rst_len", ADDR_RX_LEN, 16'h0000);
        check_rd("rst_stat", ADDR_RX_STAT, 16'h0000);

        // 1: good 5-byte frame
        p0 = int_pulses;
        for (int i = 1; i <= 5; i++) send_byte(8'(8'h11 * i));
        send_eof(1'b0);
        wait_cyc(150);
        check_eq("t1_pulses", 32'(int_pulses - p0), 32'd1);
        check_eq("t1_width", 32'(int_width), 32'd84);
        check_rd("t1_len", ADDR_RX_LEN, 16'h0005);
        check_rd("t1_stat", ADDR_RX_STAT, 16'h0001);
        for (int i = 0; i < 5; i++)
            check_rd("t1_ram", ADDR_RAM_BASE + 24'(i), 16'(8'h11 * (i + 1)));
        check_rd("t1_unmapped", 24'h000300, 16'h0000);
        emif_ack();
        check_rd("t1_stat_ack", ADDR_RX_STAT, 16'h0000);

        // 2: errored frame, then good 2-byte frame
        p0 = int_pulses;
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        send_eof(1'b1);
        wait_cyc(150);
        check_eq("t2_no_int", 32'(int_pulses - p0), 32'd0);
        check_rd("t2_stat", ADDR_RX_STAT, 16'h0100);
        check_eq("t2_state", 32'(dut.state_q), 32'(RX_IDLE));
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_eof(1'b0);
        wait_cyc(150);
        check_rd("t2_len", ADDR_RX_LEN, 16'h0002);
        check_rd("t2_stat2", ADDR_RX_STAT, 16'h0101);
        emif_ack();

        // 3: 257-byte overflow, then 3-byte frame
        p0 = int_pulses;
        for (int i = 0; i < 257; i++) send_byte(8'(i));
        send_eof(1'b0);
        wait_cyc(150);
        check_eq("t3_no_int", 32'(int_pulses - p0), 32'd0);
        check_rd("t3_stat", ADDR_RX_STAT, 16'h0102);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        send_eof(1'b0);
        wait_cyc(150);
        check_rd("t3_len", ADDR_RX_LEN, 16'h0003);
        check_rd("t3_stat2", ADDR_RX_STAT, 16'h0101);

        // 4: two frames while held are dropped
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 10; i++) send_byte(8'hE0 + 8'(i));
            send_eof(1'b0);
        end
        wait_cyc(20);
        check_rd("t4_stat", ADDR_RX_STAT, 16'h0109);
        check_rd("t4_len", ADDR_RX_LEN, 16'h0003);
        check_rd("t4_ram0", ADDR_RAM_BASE, 16'h0031);
        check_rd("t4_ram2", ADDR_RAM_BASE + 24'd2, 16'h0033);
        emif_ack();
        check_rd("t4_stat_ack", ADDR_RX_STAT, 16'h0108);
        send_byte(8'h5A);
        send_eof(1'b0);
        wait_cyc(150);
        check_rd("t4_len2", ADDR_RX_LEN, 16'h0001);
        check_rd("t4_ram_new", ADDR_RAM_BASE, 16'h005A);

        // 5: ACK in the middle of a frame being dropped
        for (int i = 0; i < 3; i++) send_byte(8'hD0 + 8'(i));
        wait_cyc(20);
        emif_ack();
        check_eq("t5_state_drop", 32'(dut.state_q), 32'(RX_DROP));
        for (int i = 3; i < 6; i++) send_byte(8'hD0 + 8'(i));
        send_eof(1'b0);
        wait_cyc(20);
        check_eq("t5_state_idle", 32'(dut.state_q), 32'(RX_IDLE));
        check_rd("t5_stat", ADDR_RX_STAT, 16'h0108);
        p0 = int_pulses;
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_eof(1'b0);
        wait_cyc(150);
        check_eq("t5_pulses", 32'(int_pulses - p0), 32'd1);
        check_rd("t5_len", ADDR_RX_LEN, 16'h0002);
        check_rd("t5_ram0", ADDR_RAM_BASE, 16'h00C1);
        check_rd("t5_ram1", ADDR_RAM_BASE + 24'd1, 16'h00C2);

        // 6: reset during RECV and during rx_int
        emif_ack();
        send_byte(8'h61);
        send_byte(8'h62);
        check_eq("t6_state_recv", 32'(dut.state_q), 32'(RX_RECV));
        check_rd("t6_ram_pre", ADDR_RAM_BASE, 16'h0061);
        do_reset();
        check_eq("t6_rdata_rst1", {16'h0, emif_rdata}, 32'h0);
        check_eq("t6_state_rst1", 32'(dut.state_q), 32'(RX_IDLE));
        release_reset();
        check_rd("t6_stat_clr", ADDR_RX_STAT, 16'h0000);
        send_byte(8'h77);
        send_eof(1'b0);
        wait_cyc(30);
        check_eq("t6_int_mid", {31'h0, rx_int}, 32'h1);
        check_rd("t6_len_mid", ADDR_RX_LEN, 16'h0001);
        do_reset();
        check_eq("t6_int_rst2", {31'h0, rx_int}, 32'h0);
        check_eq("t6_rdata_rst2", {16'h0, emif_rdata}, 32'h0);
        release_reset();
        check_rd("t6_len_clr", ADDR_RX_LEN, 16'h0000);
        send_byte(8'h99);
        send_eof(1'b0);
        wait_cyc(150);
        check_eq("t6_width", 32'(int_width), 32'd84);
        check_rd("t6_len", ADDR_RX_LEN, 16'h0001);
        check_rd("t6_ram", ADDR_RAM_BASE, 16'h0099);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
